imem_refill_responder: RTL and testbench

- Memory-side responder for the instruction-cache refill protocol: the far end of the ram_address / miss_cache / mem_word / word_ready interface driven by the fetch stage's icache controller.
- On a miss request it applies a fixed access latency, then streams one cache line as single-cycle word beats.
- Holds the instruction image in an internal word array, loaded through a preload port (testbench or boot loader).
- Sits between the fetch unit and the RAM model at core top level.

---
 rtl/imem_refill_responder.sv | 135 +++++++++++++
 tb/tb_imem_refill_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_refill_responder.sv
// Memory-side responder for icache line refills: fixed access latency, then one word beat per cycle.
// Optional IMEM_CRITICAL_WORD_FIRST_EN: burst starts at the missed word and wraps within the line.
module imem_refill_responder #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int ACCESS_LAT  = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              miss_cache,
  input  logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] mem_word,
  output logic              word_ready,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W  = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [OFF_W-1:0]    beat_cnt_q;
  logic [LINE_W-1:0]   line_q;
  logic [WORD_W-1:0]   mem_word_q;
  logic                word_ready_q;
  logic                busy_q;

  logic [WORD_W-1:0]   mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    load_idx;
  logic [OFF_W-1:0]    beat_off;
  logic [IDX_W-1:0]    rd_idx;

  // Word index drops the byte offset; upper address bits wrap silently.
  assign req_idx  = ram_address[IDX_W+1:2];
  assign load_idx = load_addr[IDX_W+1:2];

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]    start_off_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      start_off_q <= '0;
    end else if (state_q == S_IDLE && miss_cache) begin
      start_off_q <= req_idx[OFF_W-1:0];
    end
  end

  assign beat_off = start_off_q + beat_cnt_q;
`else
  assign beat_off = beat_cnt_q;
`endif

  assign rd_idx = {line_q, beat_off};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_address, load_addr};

  // Preload port; a same-edge burst read sees the previous contents.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      mem_word_q   <= '0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      word_ready_q <= 1'b0;
      mem_word_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (miss_cache) begin
            line_q    <= req_idx[IDX_W-1:OFF_W];
            lat_cnt_q <= LAT_W'(ACCESS_LAT - 1);
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == '0) begin
            beat_cnt_q <= '0;
            state_q    <= S_BURST;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_BURST: begin
          word_ready_q <= 1'b1;
          mem_word_q   <= mem_q[rd_idx];
          beat_cnt_q   <= beat_cnt_q + OFF_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold here while the request is still up so it cannot retrigger.
          if (!miss_cache) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_word   = mem_word_q;
  assign word_ready = word_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: table of refill requests plus hand-written corner sequences.
module tb_imem_refill_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        miss1, miss2;
  logic [31:0] addr1, addr2;
  logic [31:0] word1, word2;
  logic        wr1, wr2;
  logic        busy1, busy2;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_refill_responder #(
    .ADDR_W(32), .WORD_W(32), .DEPTH_WORDS(1024), .LINE_WORDS(4), .ACCESS_LAT(3)
  ) dut (
    .clk(clk), .nrst(nrst), .miss_cache(miss1), .ram_address(addr1),
    .mem_word(word1), .word_ready(wr1), .busy(busy1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_refill_responder #(
    .ADDR_W(32), .WORD_W(32), .DEPTH_WORDS(1024), .LINE_WORDS(4), .ACCESS_LAT(1)
  ) dut_lat1 (
    .clk(clk), .nrst(nrst), .miss_cache(miss2), .ram_address(addr2),
    .mem_word(word2), .word_ready(wr2), .busy(busy2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0][31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.addr   = a;
    v.exp[0] = w0;
    v.exp[1] = w1;
    v.exp[2] = w2;
    v.exp[3] = w3;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = 32'(idx) << 2;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  function automatic logic get_wr(input bit sel);
    return sel ? wr2 : wr1;
  endfunction

  function automatic logic [31:0] get_word(input bit sel);
    return sel ? word2 : word1;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy2 : busy1;
  endfunction

  task automatic set_req(input bit sel, input logic m, input logic [31:0] a);
    if (sel) begin
      miss2 = m;
      addr2 = a;
    end else begin
      miss1 = m;
      addr1 = a;
    end
  endtask

  // Full refill: capture, latency, four beats, DONE hold, release.
  task automatic run_req(input bit sel, input logic [31:0] a, input logic [3:0][31:0] exp, input string nm);
    int lat;
    lat = sel ? 1 : 3;
    set_req(sel, 1'b1, a);
    tick();
    check({nm, " busy_after_capture"}, 32'(get_busy(sel)), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      tick();
      check({nm, " no_beat_in_latency"}, 32'(get_wr(sel)), 32'd0);
    end
    for (int b = 0; b < 4; b++) begin
      tick();
      check($sformatf("%s beat%0d_ready", nm, b), 32'(get_wr(sel)), 32'd1);
      check($sformatf("%s beat%0d_data", nm, b), get_word(sel), exp[b]);
    end
    tick();
    check({nm, " done_ready_low"}, 32'(get_wr(sel)), 32'd0);
    check({nm, " done_word_zero"}, get_word(sel), 32'd0);
    check({nm, " done_busy"}, 32'(get_busy(sel)), 32'd1);
    set_req(sel, 1'b0, a);
    tick();
    check({nm, " idle_busy_low"}, 32'(get_busy(sel)), 32'd0);
  endtask

  vec_t vecs[5];
  int   beats;

  initial begin
    nrst = 1'b0; miss1 = 1'b0; miss2 = 1'b0; addr1 = '0; addr2 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
    vecs[0] = mk(32'h0000_0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vecs[1] = mk(32'h0000_001C, 32'hA7, 32'hA4, 32'hA5, 32'hA6);
    vecs[2] = mk(32'h0000_1000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vecs[3] = mk(32'h0000_0014, 32'hA5, 32'hA6, 32'hA7, 32'hA4);
    vecs[4] = mk(32'h0000_000B, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
`else
    vecs[0] = mk(32'h0000_0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vecs[1] = mk(32'h0000_001C, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
    vecs[2] = mk(32'h0000_1000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    vecs[3] = mk(32'h0000_0014, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
    vecs[4] = mk(32'h0000_000B, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif

    tick();
    tick();
    check("reset word_ready", 32'(wr1), 32'd0);
    check("reset mem_word", word1, 32'd0);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset busy lat1", 32'(busy2), 32'd0);
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      load_word(i, 32'hA0 + 32'(i));
    end

    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // ACCESS_LAT=1 instance, wrapped address lands on line 0.
    run_req(1'b1, 32'h0000_1000, vecs[2].exp, "lat1_wrap");

    // Request held for 20 cycles yields a single burst.
    miss1 = 1'b1; addr1 = 32'h0;
    tick();
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr1) beats++;
    end
    check("held_req beat_count", 32'(beats), 32'd4);
    check("held_req busy", 32'(busy1), 32'd1);
    miss1 = 1'b0;
    tick();
    check("held_req released", 32'(busy1), 32'd0);
    run_req(1'b0, 32'h0, vecs[0].exp, "rereq");

    // Reset asserted while the second beat is on the outputs.
    miss1 = 1'b1; addr1 = 32'h0;
    tick();
    for (int c = 0; c < 3; c++) tick();
    tick();
    check("rst_mid beat0", word1, 32'hA0);
    tick();
    check("rst_mid beat1", word1, 32'hA1);
    nrst = 1'b0;
    miss1 = 1'b0;
    tick();
    check("rst_mid ready", 32'(wr1), 32'd0);
    check("rst_mid word", word1, 32'd0);
    check("rst_mid busy", 32'(busy1), 32'd0);
    nrst = 1'b1;
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr1) beats++;
    end
    check("rst_mid no_more_beats", 32'(beats), 32'd0);
    run_req(1'b0, 32'h0, vecs[0].exp, "after_rst");

    // Write to word 2 lands on the same edge that beat 2 reads it.
    miss1 = 1'b1; addr1 = 32'h0;
    tick();
    for (int c = 0; c < 3; c++) tick();
    tick();
    check("rbw beat0", word1, 32'hA0);
    tick();
    check("rbw beat1", word1, 32'hA1);
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD;
    tick();
    load_en = 1'b0;
    check("rbw beat2_old", word1, 32'hA2);
    tick();
    check("rbw beat3", word1, 32'hA3);
    tick();
    miss1 = 1'b0;
    tick();
    check("rbw idle", 32'(busy1), 32'd0);
    run_req(1'b0, 32'h0, mk(32'h0, 32'hA0, 32'hA1, 32'hDEAD, 32'hA3).exp, "rbw_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
